// File: rtl/cache_mshr_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cache_mshr_if : cache-side miss, bus line-fill and fill-return signals
// Revision 1.0
// ---------------------------------------------------------------------------
interface cache_mshr_if #(
  parameter int PA_BITS = 56,
  parameter int NUMMSHR = 4
);
  localparam int IDW = $clog2(NUMMSHR);

  logic               FlushStage;
  logic               MissValid;
  logic [PA_BITS-1:0] MissPAdr;
  logic               MissWrite;
  logic               MissReady;
  logic               MissMerged;
  logic [IDW-1:0]     MissId;
  logic               BusReqValid;
  logic [PA_BITS-1:0] BusReqAdr;
  logic [IDW-1:0]     BusReqId;
  logic               BusReqReady;
  logic               FillValid;
  logic [IDW-1:0]     FillId;
  logic [PA_BITS-1:0] FillPAdr;
  logic               FillDirty;
  logic [2:0]         FillMergeCnt;
  logic               Empty;
  logic               Full;

  modport master (
    output FlushStage, MissValid, MissPAdr, MissWrite, BusReqReady, FillValid, FillId,
    input  MissReady, MissMerged, MissId, BusReqValid, BusReqAdr, BusReqId,
           FillPAdr, FillDirty, FillMergeCnt, Empty, Full
  );

  modport slave (
    input  FlushStage, MissValid, MissPAdr, MissWrite, BusReqReady, FillValid, FillId,
    output MissReady, MissMerged, MissId, BusReqValid, BusReqAdr, BusReqId,
           FillPAdr, FillDirty, FillMergeCnt, Empty, Full
  );
endinterface
`default_nettype wire

// File: rtl/cache_mshr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cache_mshr : outstanding line-miss tracker with secondary-miss merging
// Revision 1.0
// ---------------------------------------------------------------------------
module cache_mshr #(
  parameter int PA_BITS  = 56,
  parameter int LINELEN  = 512,
  parameter int NUMMSHR  = 4,
  parameter int MAXMERGE = 7
) (
  input  logic         clk,
  input  logic         reset,
  cache_mshr_if.slave  bus
);
  localparam int         OFFB      = $clog2(LINELEN/8);
  localparam int         LAW       = PA_BITS - OFFB;
  localparam int         IDW       = $clog2(NUMMSHR);
  localparam logic [2:0] C_MAXCNT  = 3'(MAXMERGE);

  typedef enum logic [1:0] {
    INVALID = 2'd0,
    PENDING = 2'd1,
    ISSUED  = 2'd2
  } ent_state_e;

  ent_state_e     state_q [NUMMSHR];
  ent_state_e     state_d [NUMMSHR];
  logic [LAW-1:0] line_q  [NUMMSHR];
  logic [LAW-1:0] line_d  [NUMMSHR];
  logic           dirty_q [NUMMSHR];
  logic           dirty_d [NUMMSHR];
  logic [2:0]     cnt_q   [NUMMSHR];
  logic [2:0]     cnt_d   [NUMMSHR];
  logic [IDW-1:0] fifo_q  [NUMMSHR];
  logic [IDW-1:0] fifo_d  [NUMMSHR];
  logic [IDW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [IDW:0]   npend_q, npend_d;

  logic [LAW-1:0]     miss_line;
  logic [NUMMSHR-1:0] valid_vec;
  logic [NUMMSHR-1:0] match_vec;
  logic               accept, fill_hit, any_match, full, alloc, issue;
  logic [IDW-1:0]     match_id, free_id;

  assign miss_line = bus.MissPAdr[PA_BITS-1:OFFB];
  assign accept    = bus.MissValid & ~bus.FlushStage;
  assign fill_hit  = bus.FillValid & (state_q[bus.FillId] == ISSUED);

  // An entry retiring this cycle must not absorb a new miss: it would be lost.
  generate
    for (genvar gi = 0; gi < NUMMSHR; gi++) begin : g_entry
      assign valid_vec[gi] = (state_q[gi] != INVALID);
      assign match_vec[gi] = valid_vec[gi] && (line_q[gi] == miss_line) &&
                             !(fill_hit && (bus.FillId == IDW'(gi)));
    end
  endgenerate

  always_comb begin
    match_id = '0;
    free_id  = '0;
    for (int i = NUMMSHR - 1; i >= 0; i--) begin
      if (match_vec[i]) match_id = IDW'(i);
      if (!valid_vec[i]) free_id = IDW'(i);
    end
  end

  assign any_match = |match_vec;
  assign full      = &valid_vec;
  assign alloc     = accept & ~any_match & ~full;
  assign issue     = bus.BusReqValid & bus.BusReqReady;

  assign bus.MissReady    = ~full;
  assign bus.Full         = full;
  assign bus.Empty        = ~|valid_vec;
  assign bus.MissMerged   = accept & any_match;
  assign bus.MissId       = any_match ? match_id : free_id;
  assign bus.BusReqValid  = (npend_q != '0);
  assign bus.BusReqId     = fifo_q[rd_q];
  assign bus.BusReqAdr    = {line_q[fifo_q[rd_q]], {OFFB{1'b0}}};
  assign bus.FillPAdr     = {line_q[bus.FillId], {OFFB{1'b0}}};
  assign bus.FillDirty    = fill_hit & dirty_q[bus.FillId];
  assign bus.FillMergeCnt = fill_hit ? cnt_q[bus.FillId] : 3'd0;

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    dirty_d = dirty_q;
    cnt_d   = cnt_q;
    fifo_d  = fifo_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    npend_d = npend_q + {{IDW{1'b0}}, alloc} - {{IDW{1'b0}}, issue};

    if (issue) begin
      state_d[bus.BusReqId] = ISSUED;
      rd_d                  = rd_q + IDW'(1);
    end
    if (accept && any_match) begin
      dirty_d[match_id] = dirty_q[match_id] | bus.MissWrite;
      if (cnt_q[match_id] < C_MAXCNT) cnt_d[match_id] = cnt_q[match_id] + 3'd1;
    end
    if (alloc) begin
      state_d[free_id] = PENDING;
      line_d[free_id]  = miss_line;
      dirty_d[free_id] = bus.MissWrite;
      cnt_d[free_id]   = 3'd0;
      fifo_d[wr_q]     = free_id;
      wr_d             = wr_q + IDW'(1);
    end
    if (fill_hit) begin
      state_d[bus.FillId] = INVALID;
      dirty_d[bus.FillId] = 1'b0;
      cnt_d[bus.FillId]   = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUMMSHR; i++) begin
        state_q[i] <= INVALID;
        line_q[i]  <= '0;
        dirty_q[i] <= 1'b0;
        cnt_q[i]   <= 3'd0;
        fifo_q[i]  <= '0;
      end
      rd_q    <= '0;
      wr_q    <= '0;
      npend_q <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      dirty_q <= dirty_d;
      cnt_q   <= cnt_d;
      fifo_q  <= fifo_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      npend_q <= npend_d;
    end
  end
endmodule
`default_nettype wire
